// File: rtl/vga_scan_ctrl_if.sv
// Pixel-request/colour-return bundle between vga_scan_ctrl and the scene renderer,
// plus the DAC/sync pins that leave the chip.
interface vga_scan_ctrl_if;
  logic [11:0] data;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [3:0]  r, g, b;
  logic        hs, vs, rdn;
  logic        frame_start;

  modport master (
    input  data,
    output x, y, r, g, b, hs, vs, rdn, frame_start
  );

  modport slave (
    output data,
    input  x, y, r, g, b, hs, vs, rdn, frame_start
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// 640x480@60 raster generator: pixel clock-enable, h/v counters, and a one-pixel
// registered output stage that keeps RGB, syncs and blanking mutually aligned.
module vga_scan_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic            clk,
  input  logic            rst,
  vga_scan_ctrl_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [9:0]    h_cnt, v_cnt;
  logic          pix_tick, h_wrap, v_wrap;
  logic          visible, hsync_on, vsync_on;

  logic [11:0]   rgb_q;
  logic          hs_q, vs_q, rdn_q, fs_q;

  assign pix_tick = (div_cnt == DIV_LAST);
  assign h_wrap   = (h_cnt == H_LAST);
  assign v_wrap   = (v_cnt == V_LAST);
  assign visible  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hsync_on = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vsync_on = (v_cnt >= VS_START) && (v_cnt < VS_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (pix_tick) begin
      div_cnt <= '0;
      h_cnt   <= h_wrap ? 10'd0 : h_cnt + 10'd1;
      if (h_wrap) v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Output stage samples the counters' current pixel, so everything lands one pixel late together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rdn_q <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      fs_q <= pix_tick && h_wrap && v_wrap;
      if (pix_tick) begin
        rgb_q <= visible ? vga.data : 12'h000;
        hs_q  <= !hsync_on;
        vs_q  <= !vsync_on;
        rdn_q <= !visible;
      end
    end
  end

  assign vga.x           = (h_cnt < H_VIS) ? h_cnt : 10'd0;
  assign vga.y           = (v_cnt < V_VIS) ? v_cnt[8:0] : 9'd0;
  assign vga.r           = rgb_q[11:8];
  assign vga.g           = rgb_q[7:4];
  assign vga.b           = rgb_q[3:0];
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.rdn         = rdn_q;
  assign vga.frame_start = fs_q;

endmodule
